dendrite_arbiter: RTL

//  Round-robin arbiter and output register sharing one dendrite unit among NUM_SYN synapse

---
 rtl/ucaspian_pkg.sv | 10 +
 rtl/dendrite_arbiter_rr_select.sv | 27 ++
 rtl/dendrite_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/ucaspian_pkg.sv
// ucaspian_pkg: shared widths and the dendrite fire record for the dendrite arbiter slice.
package ucaspian_pkg;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_CHG_W = 8;
    localparam int DEND_CHG_W = DEF_CHG_W + 1;
    typedef struct packed {
        logic [DEF_ADDR_W-1:0]        addr;
        logic signed [DEND_CHG_W-1:0] charge;
    } dend_fire_t;
endpackage

// File: rtl/dendrite_arbiter_rr_select.sv
// rr_select: combinational round-robin pick, searching upward from last+1 with wrap to 0.
module rr_select #(
    parameter int N = 5,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic          found;
    logic [IW-1:0] p;
    always_comb begin
        grant = '0;
        idx = '0;
        found = 1'b0;
        p = '0;
        for (int k = 1; k <= N; k++) begin
            p = IW'((int'(last) + k) % N);
            if (!found && req[p]) begin
                found = 1'b1;
                grant[p] = 1'b1;
                idx = p;
            end
        end
    end
endmodule

// File: rtl/dendrite_arbiter.sv
// dendrite_arbiter: round-robin share of one dendrite among synapse ports plus the incoming port.
// Define UCASPIAN_DEND_IN_PRIORITY_EN to give the incoming port strict priority.
module dendrite_arbiter
    import ucaspian_pkg::*;
#(
    parameter int NUM_SYN = 4,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CHG_W = DEF_CHG_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_SYN*ADDR_W-1:0] syn_addr,
    input  logic [NUM_SYN*CHG_W-1:0]  syn_charge,
    input  logic [NUM_SYN-1:0]        syn_vld,
    output logic [NUM_SYN-1:0]        syn_rdy,
    input  logic [ADDR_W-1:0]         in_addr,
    input  logic [CHG_W-1:0]          in_charge,
    input  logic                      in_vld,
    output logic                      in_rdy,
    output logic [ADDR_W-1:0]         dend_addr,
    output logic signed [CHG_W:0]     dend_charge,
    output logic                      dend_vld,
    input  logic                      dend_rdy
);
    localparam int IN_PORT = NUM_SYN;
    localparam int N = NUM_SYN + 1;
    localparam int IW = $clog2(N);
    logic [IW-1:0]         last_grant, rr_idx, sel_idx, next_last;
    logic [N-1:0]          req, rr_req, rr_gnt, sel_gnt, gnt;
    logic                  load;
    logic [ADDR_W-1:0]     nxt_addr;
    logic signed [CHG_W:0] nxt_chg;
    assign req = {in_vld, syn_vld};
`ifdef UCASPIAN_DEND_IN_PRIORITY_EN
    // Incoming port bypasses the rotation and leaves last_grant untouched.
    assign rr_req = {1'b0, syn_vld};
    assign sel_idx = in_vld ? IW'(IN_PORT) : rr_idx;
    assign sel_gnt = in_vld ? {1'b1, {NUM_SYN{1'b0}}} : rr_gnt;
    assign next_last = in_vld ? last_grant : rr_idx;
`else
    assign rr_req = req;
    assign sel_idx = rr_idx;
    assign sel_gnt = rr_gnt;
    assign next_last = rr_idx;
`endif
    rr_select #(.N(N), .IW(IW)) u_rr (
        .req  (rr_req),
        .last (last_grant),
        .grant(rr_gnt),
        .idx  (rr_idx)
    );
    assign load = ~reset & enable & (~dend_vld | dend_rdy) & (|req);
    assign gnt = load ? sel_gnt : '0;
    assign syn_rdy = gnt[NUM_SYN-1:0];
    assign in_rdy = gnt[IN_PORT];
    // Synapse charges are signed; host charges are unsigned magnitudes.
    always_comb begin
        nxt_addr = in_addr;
        nxt_chg = {1'b0, in_charge};
        for (int i = 0; i < NUM_SYN; i++) begin
            if (sel_idx == IW'(i)) begin
                nxt_addr = syn_addr[i*ADDR_W +: ADDR_W];
                nxt_chg = {syn_charge[(i+1)*CHG_W-1], syn_charge[i*CHG_W +: CHG_W]};
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            dend_vld <= 1'b0;
            dend_addr <= '0;
            dend_charge <= '0;
            last_grant <= IW'(IN_PORT);
        end else if (load) begin
            dend_vld <= 1'b1;
            dend_addr <= nxt_addr;
            dend_charge <= nxt_chg;
            last_grant <= next_last;
        end else if (dend_rdy) begin
            dend_vld <= 1'b0;
        end
    end
endmodule
